// File: rtl/freq_div_pkg.sv
// Shared constants and elaboration helpers for freq_div.
package freq_div_pkg;

    localparam int MAX_N = 65535;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/freq_div.sv
// Integer clock divider: clk_div = f_clk/N, pass-through for N<=1.
// FREQ_DIV_ODD_DUTY50_EN adds a falling-edge stage giving 50% duty for odd N.
module freq_div
    import freq_div_pkg::*;
#(
    parameter int N = 2
) (
    output logic clk_div,
    input  logic clk,
    input  logic reset
);

    localparam int CNT_W = clog2_min1(N);
    localparam int HALF  = N / 2;

    if (N < 0 || N > MAX_N) begin : g_range_err
        $error("freq_div: N=%0d outside 0..%0d", N, MAX_N);
    end

    if (N <= 1) begin : g_pass
        // Combinational gate: only suitable where glitches are tolerated.
        assign clk_div = clk & ~reset;
    end else begin : g_div
        localparam logic [CNT_W-1:0] LAST   = CNT_W'(N - 1);
        localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             q_q, q_d;

        // '>=' also folds any out-of-range count back to zero.
        always_comb begin
            q_d   = (cnt_q < HALF_C);
            cnt_d = (cnt_q >= LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                q_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                q_q   <= q_d;
            end
        end

`ifdef FREQ_DIV_ODD_DUTY50_EN
        if (N % 2 == 1) begin : g_odd
            logic qn_q;

            // Half-cycle delayed copy stretches the high phase by half a period.
            always_ff @(negedge clk) begin
                qn_q <= reset ? 1'b0 : q_q;
            end

            assign clk_div = q_q | qn_q;
        end else begin : g_even
            assign clk_div = q_q;
        end
`else
        assign clk_div = q_q;
`endif
    end

endmodule

// File: tb/tb_freq_div.sv
// Bench for freq_div: ratios 0,1,2,3,4,5,10 against a phase-arithmetic model.
module tb_freq_div;

    localparam int NI = 7;
    localparam int NS [NI] = '{0, 1, 2, 3, 4, 5, 10};
`ifdef FREQ_DIV_ODD_DUTY50_EN
    localparam bit ODD_EN = 1'b1;
`else
    localparam bit ODD_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] dv;

    int checks = 0;
    int errors = 0;

    // Model state: k = rising edges since reset release (-1 while in reset).
    int k = -1;
    bit qn_m [NI];

    always #5 clk = ~clk;

    freq_div #(.N(0))  u_n0  (.clk_div(dv[0]), .clk(clk), .reset(reset));
    freq_div #(.N(1))  u_n1  (.clk_div(dv[1]), .clk(clk), .reset(reset));
    freq_div #(.N(2))  u_n2  (.clk_div(dv[2]), .clk(clk), .reset(reset));
    freq_div #(.N(3))  u_n3  (.clk_div(dv[3]), .clk(clk), .reset(reset));
    freq_div #(.N(4))  u_n4  (.clk_div(dv[4]), .clk(clk), .reset(reset));
    freq_div #(.N(5))  u_n5  (.clk_div(dv[5]), .clk(clk), .reset(reset));
    freq_div #(.N(10)) u_n10 (.clk_div(dv[6]), .clk(clk), .reset(reset));

    // Base-mode output after edge k: high for the first floor(N/2) edges of each period.
    function automatic bit q_model(int i);
        return (k >= 0) && ((k % NS[i]) < (NS[i] / 2));
    endfunction

    function automatic logic [NI-1:0] model_out(bit hi_phase);
        logic [NI-1:0] e;
        for (int i = 0; i < NI; i++) begin
            if (NS[i] <= 1)
                e[i] = hi_phase & ~reset;
            else
                e[i] = q_model(i) | (ODD_EN && (NS[i] % 2 == 1) && qn_m[i]);
        end
        return e;
    endfunction

    // Advance to just after the rising edge; inputs only change after the falling edge.
    task automatic edge_hi();
        @(posedge clk);
        k = reset ? -1 : k + 1;
        #1;
    endtask

    task automatic edge_lo();
        @(negedge clk);
        for (int i = 0; i < NI; i++) qn_m[i] = reset ? 1'b0 : q_model(i);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) begin
            edge_hi();
            checks++;
            if (dv !== '0) begin
                errors++;
                $display("FAIL reset_hi t=%0t got=%b want=%b", $time, dv, {NI{1'b0}});
            end
            edge_lo();
            checks++;
            if (dv !== '0) begin
                errors++;
                $display("FAIL reset_lo t=%0t got=%b want=%b", $time, dv, {NI{1'b0}});
            end
        end
    endtask

    task automatic test_divide();
        int hi10, hi3, hi5, hi0;
        logic [NI-1:0] exp;
        hi10 = 0; hi3 = 0; hi5 = 0; hi0 = 0;
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            edge_hi();
            exp = model_out(1'b1);
            checks++;
            if (dv !== exp) begin
                errors++;
                $display("FAIL divide_hi c=%0d got=%b want=%b", c, dv, exp);
            end
            if (c < 4) begin
                checks++;
                if (dv[2] !== logic'(c % 2 == 0)) begin
                    errors++;
                    $display("FAIL n2_pattern c=%0d got=%b want=%b", c, dv[2], c % 2 == 0);
                end
            end
            hi10 += int'(dv[6]); hi3 += int'(dv[3]); hi5 += int'(dv[5]); hi0 += int'(dv[0]);
            edge_lo();
            exp = model_out(1'b0);
            checks++;
            if (dv !== exp) begin
                errors++;
                $display("FAIL divide_lo c=%0d got=%b want=%b", c, dv, exp);
            end
            hi10 += int'(dv[6]); hi3 += int'(dv[3]); hi5 += int'(dv[5]); hi0 += int'(dv[0]);
        end
        // High time in half-cycles over 30 clocks: N=10 x3, N=3 x10, N=5 x6 periods.
        checks++;
        if (hi10 !== 30) begin
            errors++;
            $display("FAIL n10_hightime got=%0d want=%0d", hi10, 30);
        end
        checks++;
        if (hi3 !== (ODD_EN ? 30 : 20)) begin
            errors++;
            $display("FAIL n3_hightime got=%0d want=%0d", hi3, ODD_EN ? 30 : 20);
        end
        checks++;
        if (hi5 !== (ODD_EN ? 30 : 24)) begin
            errors++;
            $display("FAIL n5_hightime got=%0d want=%0d", hi5, ODD_EN ? 30 : 24);
        end
        checks++;
        if (hi0 !== 30) begin
            errors++;
            $display("FAIL n0_passthru_hightime got=%0d want=%0d", hi0, 30);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        logic [NI-1:0] exp;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            edge_hi();
            exp = model_out(1'b1);
            checks++;
            if (dv !== exp) begin
                errors++;
                $display("FAIL midrst_seek_hi got=%b want=%b", dv, exp);
            end
            // After this edge the N=10 count sits at 7.
            if (k % 10 == 6) found = 1'b1;
            edge_lo();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_seek_timeout got=%0d want=%0d", k % 10, 6);
        end
        reset = 1'b1;
        edge_hi();
        checks++;
        if (dv[6] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_n10_zero got=%b want=0", dv[6]);
        end
        exp = model_out(1'b1);
        checks++;
        if (dv !== exp) begin
            errors++;
            $display("FAIL midrst_all got=%b want=%b", dv, exp);
        end
        edge_lo();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            edge_hi();
            checks++;
            if (dv[6] !== logic'(c < 5)) begin
                errors++;
                $display("FAIL midrst_restart c=%0d got=%b want=%b", c, dv[6], c < 5);
            end
            exp = model_out(1'b1);
            checks++;
            if (dv !== exp) begin
                errors++;
                $display("FAIL midrst_restart_all c=%0d got=%b want=%b", c, dv, exp);
            end
            edge_lo();
        end
    endtask

    task automatic test_random();
        logic [NI-1:0] exp;
        for (int c = 0; c < 300; c++) begin
            edge_hi();
            exp = model_out(1'b1);
            checks++;
            if (dv !== exp) begin
                errors++;
                $display("FAIL random_hi c=%0d rst=%b got=%b want=%b", c, reset, dv, exp);
            end
            edge_lo();
            exp = model_out(1'b0);
            checks++;
            if (dv !== exp) begin
                errors++;
                $display("FAIL random_lo c=%0d rst=%b got=%b want=%b", c, reset, dv, exp);
            end
            reset = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) qn_m[i] = 1'b0;
        test_reset();
        test_divide();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
